// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Handshaked execute-stage ALU. Single-cycle ops complete
//                with latency 1. MUL/MULHU use an iterative shift-add
//                multiplier. DIVU/REMU use an iterative restoring divider,
//                which is present only when the macro ALU_DIV_EN is defined.
//                Without ALU_DIV_EN, ctrl 1110/1111 are single-cycle and
//                return zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [3:0]       ctrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             eq
);

   // Opcode encodings.
   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_EQ    = 4'b0101;
   localparam logic [3:0] OP_SLT   = 4'b0110;
   localparam logic [3:0] OP_SLTU  = 4'b0111;
   localparam logic [3:0] OP_SLL   = 4'b1000;
   localparam logic [3:0] OP_SRL   = 4'b1001;
   localparam logic [3:0] OP_SRA   = 4'b1010;

   // Iteration count: one step per cycle, counting WIDTH-1 down to 0.
   localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state;
   logic [SHW-1:0]       cnt;

   // Multiplier: accumulator holds {partial_high, remaining_multiplier}.
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     mcand;
   logic                 want_hi;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;

`ifdef ALU_DIV_EN
   // Divider: partial remainder, dividend shifting into quotient, divisor.
   logic [WIDTH-1:0]     rem;
   logic [WIDTH-1:0]     quo;
   logic [WIDTH-1:0]     dvsr;
   logic                 want_rem;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_diff;
   logic                 div_ok;
   logic [WIDTH-1:0]     rem_next;
   logic [WIDTH-1:0]     quo_next;
   logic                 is_div;
`endif

   logic                 accept;
   logic                 is_mul;
   logic [SHW-1:0]       shamt;
   logic [WIDTH-1:0]     sc_result;
   logic                 sc_eq;

   assign in_ready = (state == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign is_mul   = (ctrl[3:1] == 3'b110);
   assign shamt    = op2[SHW-1:0];

   // Single-cycle result; unsupported codes (and 1110/1111 when no divider) give 0.
   always_comb begin
      sc_result = '0;
      sc_eq     = 1'b0;
      case (ctrl)
         OP_ADD:  sc_result = op1 + op2;
         OP_SUB:  sc_result = op1 - op2;
         OP_AND:  sc_result = op1 & op2;
         OP_OR:   sc_result = op1 | op2;
         OP_XOR:  sc_result = op1 ^ op2;
         OP_EQ:   sc_eq     = (op1 == op2);
         OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
         OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (op1 < op2)};
         OP_SLL:  sc_result = op1 << shamt;
         OP_SRL:  sc_result = op1 >> shamt;
         OP_SRA:  sc_result = WIDTH'($signed(op1) >>> shamt);
         default: sc_result = '0;
      endcase
   end

   // One shift-add step: add multiplicand when the current multiplier bit is set,
   // then shift the whole accumulator right, keeping the carry.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      mul_next = {mul_sum, acc[WIDTH-1:1]};
   end

`ifdef ALU_DIV_EN
   assign is_div = (ctrl[3:1] == 3'b111);

   // One restoring step: shift in the next dividend bit and subtract the divisor
   // if it fits. A zero divisor always fits, giving all-ones quotient and
   // remainder equal to the dividend without special casing.
   always_comb begin
      div_shift = {rem, quo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, dvsr};
      div_ok    = !div_diff[WIDTH];
      rem_next  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      quo_next  = {quo[WIDTH-2:0], div_ok};
   end
`endif

   // Control FSM with registered result, eq and out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         eq        <= 1'b0;
         cnt       <= '0;
         acc       <= '0;
         mcand     <= '0;
         want_hi   <= 1'b0;
`ifdef ALU_DIV_EN
         rem       <= '0;
         quo       <= '0;
         dvsr      <= '0;
         want_rem  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     state     <= MUL;
                     cnt       <= CNT_INIT;
                     acc       <= {{WIDTH{1'b0}}, op1};
                     mcand     <= op2;
                     want_hi   <= ctrl[0];
                     out_valid <= 1'b0;
                  end
`ifdef ALU_DIV_EN
                  else if (is_div) begin
                     state     <= DIV;
                     cnt       <= CNT_INIT;
                     rem       <= '0;
                     quo       <= op1;
                     dvsr      <= op2;
                     want_rem  <= ctrl[0];
                     out_valid <= 1'b0;
                  end
`endif
                  else begin
                     // Back-to-back single-cycle ops keep out_valid high.
                     result    <= sc_result;
                     eq        <= sc_eq;
                     out_valid <= 1'b1;
                  end
               end else if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end

            MUL: begin
               acc <= mul_next;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  result    <= want_hi ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
                  eq        <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end

`ifdef ALU_DIV_EN
            DIV: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  result    <= want_rem ? rem_next : quo_next;
                  eq        <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
`endif

            DONE: begin
               // Result waits here until the consumer takes it.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq (WIDTH=32). A driver issues
//                directed operations and queues the expected result/eq; a
//                monitor pops and compares on every output transfer.
//                Expected division results depend on ALU_DIV_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

   localparam int W = 32;
`ifdef ALU_DIV_EN
   localparam bit DIV_ON = 1'b1;
`else
   localparam bit DIV_ON = 1'b0;
`endif
   localparam int LDIV = DIV_ON ? 33 : 1;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  op1;
   logic [W-1:0]  op2;
   logic [3:0]    ctrl;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          eq;

   int            total = 0;
   int            bad   = 0;
   logic [W:0]    sb[$];

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op1       (op1),
      .op2       (op2),
      .ctrl      (ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .eq        (eq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: compare on each output transfer.
   initial begin
      logic [W:0] e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected output", 64'(result), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("sb result", 64'(result), 64'(e[W-1:0]));
               check("sb eq", 64'(eq), 64'(e[W]));
            end
         end
      end
   end

   // Wait (bounded) for in_ready with the op presented, then take the accept edge.
   task automatic present(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
      int n;
      op1 = a; op2 = b; ctrl = c; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      check("in_ready wait", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
   endtask

   // Issue one op, check its latency and that in_ready stays low while busy.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                       input logic [W-1:0] er, input logic ee, input int lat, input string nm);
      int cyc;
      int rdy;
      sb.push_back({ee, er});
      present(a, b, c);
      in_valid = 1'b0;
      op1 = 32'hDEAD_BEEF; op2 = 32'h1234_5678; ctrl = 4'b0001;
      cyc = 1; rdy = 0;
      while (!out_valid && cyc < 200) begin
         if (in_ready) rdy++;
         @(posedge clk); #1; cyc++;
      end
      check({nm, " latency"}, 64'(cyc), 64'(lat));
      if (lat > 1) check({nm, " in_ready busy"}, 64'(rdy), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int stall_err;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op1 = '0; op2 = '0; ctrl = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset result", 64'(result), 64'd0);
      check("reset eq", 64'(eq), 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: ADD wrap, then SUB back-to-back.
      sb.push_back({1'b0, 32'h0000_0000});
      present(32'hFFFF_FFFF, 32'h1, 4'b0000);
      check("add latency", 64'(out_valid), 64'd1);
      sb.push_back({1'b0, 32'hFFFF_FFFE});
      op1 = 32'd5; op2 = 32'd7; ctrl = 4'b0001;
      check("b2b in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("b2b out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      check("out_valid drop", 64'(out_valid), 64'd0);

      // 2: single-cycle set.
      send(32'h8000_0000, 32'h24, 4'b1010, 32'hF800_0000, 1'b0, 1, "sra");
      send(32'h8000_0000, 32'h24, 4'b1001, 32'h0800_0000, 1'b0, 1, "srl");
      send(32'h1, 32'h1F, 4'b1000, 32'h8000_0000, 1'b0, 1, "sll");
      send(32'hFFFF_FFFF, 32'h1, 4'b0110, 32'h1, 1'b0, 1, "slt");
      send(32'h1, 32'hFFFF_FFFF, 4'b0110, 32'h0, 1'b0, 1, "slt2");
      send(32'hFFFF_FFFF, 32'h1, 4'b0111, 32'h0, 1'b0, 1, "sltu");
      send(32'd7, 32'd7, 4'b0101, 32'h0, 1'b1, 1, "eq");
      send(32'd7, 32'd8, 4'b0101, 32'h0, 1'b0, 1, "neq");
      send(32'hF0F0_FF00, 32'h0FF0_F0F0, 4'b0010, 32'h00F0_F000, 1'b0, 1, "and");
      send(32'hF0F0_FF00, 32'h0FF0_F0F0, 4'b0011, 32'hFFF0_FFF0, 1'b0, 1, "or");
      send(32'hF0F0_FF00, 32'h0FF0_F0F0, 4'b0100, 32'hFF00_0FF0, 1'b0, 1, "xor");
      send(32'd9, 32'd3, 4'b1011, 32'h0, 1'b0, 1, "unsup");

      // 3: multiply.
      send(32'h1_0000, 32'h1_0000, 4'b1100, 32'h0, 1'b0, 33, "mul");
      send(32'h1_0000, 32'h1_0000, 4'b1101, 32'h1, 1'b0, 33, "mulhu");
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1100, 32'h1, 1'b0, 33, "mul max");
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1101, 32'hFFFF_FFFE, 1'b0, 33, "mulhu max");

      // 4: divide (or unsupported without the divider).
      send(32'd100, 32'd7, 4'b1110, DIV_ON ? 32'd14 : 32'd0, 1'b0, LDIV, "divu");
      send(32'd100, 32'd7, 4'b1111, DIV_ON ? 32'd2 : 32'd0, 1'b0, LDIV, "remu");
      send(32'h1234_5678, 32'd0, 4'b1110, DIV_ON ? 32'hFFFF_FFFF : 32'd0, 1'b0, LDIV, "divu0");
      send(32'd9, 32'd0, 4'b1111, DIV_ON ? 32'd9 : 32'd0, 1'b0, LDIV, "remu0");
      send(32'hFFFF_FFFF, 32'h10, 4'b1110, DIV_ON ? 32'h0FFF_FFFF : 32'd0, 1'b0, LDIV, "divu big");

      // 5: completed MUL held with out_ready low.
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(32'd3, 32'd5, 4'b1100, 32'd15, 1'b0, 33, "mul stall");
      sb.push_back({1'b0, 32'd2});
      op1 = 32'd1; op2 = 32'd1; ctrl = 4'b0000; in_valid = 1'b1;
      stall_err = 0;
      for (int i = 0; i < 10; i++) begin
         if (in_ready || !out_valid || result != 32'd15) stall_err++;
         @(posedge clk); #1;
      end
      check("stall hold", 64'(stall_err), 64'd0);
      check("stall queue", 64'(sb.size()), 64'd2);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release in_ready", 64'(in_ready), 64'd1);
      check("release out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("post-stall add valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;

      // 6: async reset in the middle of a multiply.
      present(32'h1_0000, 32'h3, 4'b1100);
      in_valid = 1'b0;
      repeat (11) begin
         @(posedge clk); #1;
      end
      check("pre-reset result", 64'(result), 64'd2);
      #2;
      rst = 1'b1;
      sb.delete();
      #1;
      check("async rst out_valid", 64'(out_valid), 64'd0);
      check("async rst result", 64'(result), 64'd0);
      @(negedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #1;
      check("post-rst in_ready", 64'(in_ready), 64'd1);
      send(32'd2, 32'd3, 4'b0000, 32'd5, 1'b0, 1, "post-rst add");
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("queue drained", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
